// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register-bank responder and its storage cells.
// Also holds the default register-bus request/response structs used at 32-bit width.
package reg_bank_pkg;

   typedef enum logic [1:0] {
      Idle,
      Wait,
      Resp
   } state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

   // Number of address bits that select a byte within one bus word.
   function automatic int unsigned byte_off_width(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// One register of the bank: byte-masked bus write merged with a full-word hardware write.
// Bus bytes with their strobe set take priority; all other bytes follow the hardware write.
module reg_bank_cell #(
   parameter int unsigned          DataWidth = 32,
   parameter logic [DataWidth-1:0] ResetVal  = '0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   bus_we_i,
   input  logic [DataWidth/8-1:0] bus_wstrb_i,
   input  logic [DataWidth-1:0]   bus_wdata_i,
   input  logic                   hw_we_i,
   input  logic [DataWidth-1:0]   hw_wdata_i,
   output logic [DataWidth-1:0]   q_o
);

   localparam int unsigned StrbW = DataWidth / 8;

   logic [DataWidth-1:0] data_q, data_d;

   always_comb begin
      // NOTE: default assigned first so every path drives data_d and no latch is inferred.
      data_d = data_q;
      for (int k = 0; k < StrbW; k++) begin
         if (bus_we_i && bus_wstrb_i[k]) begin
            data_d[8*k +: 8] = bus_wdata_i[8*k +: 8];
         end else if (hw_we_i) begin
            data_d[8*k +: 8] = hw_wdata_i[8*k +: 8];
         end
      end
   end

   // NOTE: each register carries its own reset value, so the bank is flops, not a RAM macro.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= ResetVal;
      end else begin
         // NOTE: non-blocking assignment for state so all flops update from pre-edge values.
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/reg_bank_responder.sv
// Device-side register-bus endpoint: a bank of byte-strobed registers with read-only
// mask, programmable response latency and a hardware-side write port.
module reg_bank_responder
   import reg_bank_pkg::*;
#(
   parameter int unsigned                   NumRegs      = 8,
   parameter int unsigned                   AddrWidth    = 32,
   parameter int unsigned                   DataWidth    = 32,
   parameter int unsigned                   Latency      = 1,
   parameter logic [NumRegs-1:0]            ReadOnlyMask = '0,
   parameter logic [NumRegs*DataWidth-1:0]  ResetVal     = '0,
   parameter type                           req_t        = reg_req_t,
   parameter type                           rsp_t        = reg_rsp_t
) (
   input  logic                                              clk_i,
   input  logic                                              rst_ni,
   input  req_t                                              reg_req_i,
   output rsp_t                                              reg_rsp_o,
   output logic [NumRegs*DataWidth-1:0]                      reg_q_o,
   input  logic                                              hw_we_i,
   input  logic [((NumRegs > 1) ? $clog2(NumRegs) : 1)-1:0]  hw_idx_i,
   input  logic [DataWidth-1:0]                              hw_wdata_i,
   output logic [NumRegs-1:0]                                bus_wr_o
);

   localparam int unsigned OffW     = byte_off_width(DataWidth);
   localparam int unsigned StrbW    = DataWidth / 8;
   localparam int unsigned IdxW     = (NumRegs > 1) ? $clog2(NumRegs) : 1;
   localparam int unsigned IdxFullW = AddrWidth - OffW;
   localparam int unsigned CntW     = (Latency > 1) ? $clog2(Latency) : 1;

   logic [AddrWidth-1:0] addr;
   logic                 write;
   logic [DataWidth-1:0] wdata;
   logic [StrbW-1:0]     wstrb;
   logic                 valid;

   assign addr  = reg_req_i.addr;
   assign write = reg_req_i.write;
   assign wdata = reg_req_i.wdata;
   assign wstrb = reg_req_i.wstrb;
   assign valid = reg_req_i.valid;

   logic [IdxFullW-1:0]  idx_full;
   logic [IdxW-1:0]      idx;
   logic                 in_range;
   logic                 misaligned;
   logic                 acc_err;
   logic                 fire;
   logic                 wr_commit;
   logic [DataWidth-1:0] reg_q [NumRegs];
   logic [DataWidth-1:0] rd_val;
   logic [NumRegs-1:0]   bus_wr_d, bus_wr_q;

   assign idx_full   = addr[AddrWidth-1:OffW];
   assign idx        = idx_full[IdxW-1:0];
   assign in_range   = (idx_full < IdxFullW'(NumRegs));
   assign misaligned = |addr[OffW-1:0];
   assign acc_err    = misaligned || !in_range || (write && ReadOnlyMask[idx]);
   assign rd_val     = reg_q[idx];
   assign wr_commit  = fire && write && !acc_err;

   generate
      if (Latency == 0) begin : g_comb
         assign fire = valid;
      end else begin : g_fsm
         state_e          state_q, state_d;
         logic [CntW-1:0] cnt_q, cnt_d;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               state_q <= Idle;
               cnt_q   <= '0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
            end
         end

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
               Idle: begin
                  if (valid) begin
                     if (Latency == 1) begin
                        state_d = Resp;
                     end else begin
                        cnt_d   = CntW'(Latency - 1);
                        state_d = Wait;
                     end
                  end
               end
               Wait: begin
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == CntW'(1)) state_d = Resp;
               end
               Resp:    state_d = Idle;
               default: state_d = Idle;
            endcase
         end

         // Resp completes even if the requester misbehaves; the property below flags it.
         assign fire = (state_q == Resp);

         valid_held_a: assert property (
            @(posedge clk_i) disable iff (!rst_ni) (state_q != Idle) |-> valid
         );
      end
   endgenerate

   always_comb begin
      reg_rsp_o       = '0;
      reg_rsp_o.ready = fire;
      reg_rsp_o.error = fire && acc_err;
      reg_rsp_o.rdata = (fire && !acc_err && !write) ? rd_val : '0;
   end

   always_comb begin
      bus_wr_d = '0;
      for (int i = 0; i < NumRegs; i++) begin
         bus_wr_d[i] = wr_commit && (idx == IdxW'(i));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bus_wr_q <= '0;
      end else begin
         bus_wr_q <= bus_wr_d;
      end
   end

   assign bus_wr_o = bus_wr_q;

   for (genvar i = 0; i < NumRegs; i++) begin : g_cell
      reg_bank_cell #(
         .DataWidth (DataWidth),
         .ResetVal  (ResetVal[i*DataWidth +: DataWidth])
      ) u_cell (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .bus_we_i    (bus_wr_d[i]),
         .bus_wstrb_i (wstrb),
         .bus_wdata_i (wdata),
         .hw_we_i     (hw_we_i && (hw_idx_i == IdxW'(i))),
         .hw_wdata_i  (hw_wdata_i),
         .q_o         (reg_q[i])
      );
      assign reg_q_o[i*DataWidth +: DataWidth] = reg_q[i];
   end

endmodule

// File: tb/tb_reg_bank_responder.sv
// Directed bench for reg_bank_responder at latencies 2, 0 and 3, with a response scoreboard.
module tb_reg_bank_responder;
   import reg_bank_pkg::*;

   localparam logic [255:0] RV_L2 = {128'h0, 32'h33333333, 64'h0, 32'h11223344};
   localparam logic [255:0] RV_L0 = {192'h0, 32'hB1B1B1B1, 32'hA0A0A0A0};
   localparam logic [255:0] RV_L3 = {192'h0, 32'hCAFEF00D, 32'h0};

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         rst3_n;
   reg_req_t     req    [3];
   reg_rsp_t     rsp    [3];
   logic [255:0] regq   [3];
   logic         hw_we  [3];
   logic [2:0]   hw_idx [3];
   logic [31:0]  hw_wd  [3];
   logic [7:0]   bwr    [3];

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   reg_bank_responder #(.Latency(2), .ReadOnlyMask(8'h08), .ResetVal(RV_L2)) u_l2 (
      .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req[0]), .reg_rsp_o(rsp[0]), .reg_q_o(regq[0]),
      .hw_we_i(hw_we[0]), .hw_idx_i(hw_idx[0]), .hw_wdata_i(hw_wd[0]), .bus_wr_o(bwr[0]));

   reg_bank_responder #(.Latency(0), .ResetVal(RV_L0)) u_l0 (
      .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req[1]), .reg_rsp_o(rsp[1]), .reg_q_o(regq[1]),
      .hw_we_i(hw_we[1]), .hw_idx_i(hw_idx[1]), .hw_wdata_i(hw_wd[1]), .bus_wr_o(bwr[1]));

   reg_bank_responder #(.Latency(3), .ResetVal(RV_L3)) u_l3 (
      .clk_i(clk), .rst_ni(rst3_n), .reg_req_i(req[2]), .reg_rsp_o(rsp[2]), .reg_q_o(regq[2]),
      .hw_we_i(hw_we[2]), .hw_idx_i(hw_idx[2]), .hw_wdata_i(hw_wd[2]), .bus_wr_o(bwr[2]));

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] slice(input int d, input int i);
      logic [255:0] v;
      v = regq[d];
      return v[i*32 +: 32];
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Drive one request, push its expected response, pop and compare when ready appears.
   // Optionally fires a hardware write in the commit cycle.
   task automatic txn(input int d, input string tag, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [3:0] strb, input int exp_lat,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input logic hw_en = 1'b0, input logic [2:0] hwi = '0,
                      input logic [31:0] hwd = '0);
      exp_t e;
      int   cyc;
      bit   seen;
      req[d] = '{addr: addr, write: wr, wdata: wdata, wstrb: strb, valid: 1'b1};
      sb.push_back('{rdata: exp_rdata, err: exp_err});
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc <= 20) begin
         @(negedge clk);
         if (rsp[d].ready) seen = 1'b1;
         else cyc++;
      end
      e = sb.pop_front();
      check({tag, "_ready_seen"}, 256'(seen), 256'(1));
      if (seen) begin
         check({tag, "_latency"}, 256'(cyc), 256'(exp_lat));
         check({tag, "_rdata"}, 256'(rsp[d].rdata), 256'(e.rdata));
         check({tag, "_error"}, 256'(rsp[d].error), 256'(e.err));
      end
      if (hw_en) begin
         hw_we[d]  = 1'b1;
         hw_idx[d] = hwi;
         hw_wd[d]  = hwd;
      end
      sync();
      req[d]   = '0;
      hw_we[d] = 1'b0;
   endtask

   // One cycle after a transaction: check the bus_wr pulse and that ready has dropped.
   task automatic post(input int d, input string tag, input logic [7:0] exp_bwr);
      @(negedge clk);
      check({tag, "_bus_wr"}, 256'(bwr[d]), 256'(exp_bwr));
      check({tag, "_ready_low"}, 256'(rsp[d].ready), 256'(0));
      sync();
   endtask

   initial begin
      rst_n  = 1'b0;
      rst3_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         req[d]    = '0;
         hw_we[d]  = 1'b0;
         hw_idx[d] = '0;
         hw_wd[d]  = '0;
      end
      repeat (2) @(negedge clk);
      check("rst_regs_l2", regq[0], RV_L2);
      check("rst_regs_l0", regq[1], RV_L0);
      check("rst_regs_l3", regq[2], RV_L3);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_ready_%0d", d), 256'(rsp[d].ready), 256'(0));
         check($sformatf("rst_rdata_%0d", d), 256'(rsp[d].rdata), 256'(0));
         check($sformatf("rst_error_%0d", d), 256'(rsp[d].error), 256'(0));
         check($sformatf("rst_bus_wr_%0d", d), 256'(bwr[d]), 256'(0));
      end
      rst_n  = 1'b1;
      rst3_n = 1'b1;
      sync();

      // Latency 2 instance
      txn(0, "l2_wr1", 32'h4, 1'b1, 32'hDEADBEEF, 4'hF, 2, 32'h0, 1'b0);
      post(0, "l2_wr1", 8'h02);
      check("l2_wr1_reg1", 256'(slice(0, 1)), 256'(32'hDEADBEEF));
      post(0, "l2_wr1_end", 8'h00);

      txn(0, "l2_part", 32'h0, 1'b1, 32'hAABBCCDD, 4'b0101, 2, 32'h0, 1'b0);
      post(0, "l2_part", 8'h01);
      check("l2_part_reg0", 256'(slice(0, 0)), 256'(32'h11BB33DD));
      txn(0, "l2_rd0", 32'h0, 1'b0, 32'h0, 4'h0, 2, 32'h11BB33DD, 1'b0);

      txn(0, "l2_misalign", 32'h2, 1'b0, 32'h0, 4'h0, 2, 32'h0, 1'b1);
      txn(0, "l2_oor", 32'h20, 1'b0, 32'h0, 4'h0, 2, 32'h0, 1'b1);
      txn(0, "l2_ro_wr", 32'hC, 1'b1, 32'hFFFFFFFF, 4'hF, 2, 32'h0, 1'b1);
      post(0, "l2_ro_wr", 8'h00);
      check("l2_err_state", regq[0],
            {128'h0, 32'h33333333, 32'h0, 32'hDEADBEEF, 32'h11BB33DD});
      txn(0, "l2_rd3", 32'hC, 1'b0, 32'h0, 4'h0, 2, 32'h33333333, 1'b0);

      txn(0, "l2_conflict", 32'h8, 1'b1, 32'hFFFF0000, 4'b1100, 2, 32'h0, 1'b0,
          1'b1, 3'd2, 32'h12345678);
      post(0, "l2_conflict", 8'h04);
      check("l2_conflict_reg2", 256'(slice(0, 2)), 256'(32'hFFFF5678));

      hw_we[0] = 1'b1; hw_idx[0] = 3'd3; hw_wd[0] = 32'h0BADF00D;
      sync();
      hw_we[0] = 1'b0;
      check("l2_hw_ro_reg3", 256'(slice(0, 3)), 256'(32'h0BADF00D));
      txn(0, "l2_rd3_hw", 32'hC, 1'b0, 32'h0, 4'h0, 2, 32'h0BADF00D, 1'b0);

      txn(0, "l2_nostrb", 32'h10, 1'b1, 32'h99999999, 4'h0, 2, 32'h0, 1'b0);
      post(0, "l2_nostrb", 8'h10);
      check("l2_nostrb_reg4", 256'(slice(0, 4)), 256'(32'h0));

      // Latency 0 instance: back-to-back reads on consecutive cycles
      txn(1, "l0_rd0", 32'h0, 1'b0, 32'h0, 4'h0, 0, 32'hA0A0A0A0, 1'b0);
      txn(1, "l0_rd1", 32'h4, 1'b0, 32'h0, 4'h0, 0, 32'hB1B1B1B1, 1'b0);
      txn(1, "l0_wr2", 32'h8, 1'b1, 32'h5555AAAA, 4'hF, 0, 32'h0, 1'b0);
      post(1, "l0_wr2", 8'h04);
      check("l0_wr2_reg2", 256'(slice(1, 2)), 256'(32'h5555AAAA));
      txn(1, "l0_oor", 32'h24, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b1);

      // Latency 3 instance: reset during Wait aborts the write
      hw_we[2] = 1'b1; hw_idx[2] = 3'd1; hw_wd[2] = 32'h77777777;
      sync();
      hw_we[2] = 1'b0;
      check("l3_hw_reg1", 256'(slice(2, 1)), 256'(32'h77777777));
      req[2] = '{addr: 32'h4, write: 1'b1, wdata: 32'h12121212, wstrb: 4'hF, valid: 1'b1};
      @(negedge clk);
      check("l3_idle_ready", 256'(rsp[2].ready), 256'(0));
      @(negedge clk);
      check("l3_wait_ready", 256'(rsp[2].ready), 256'(0));
      rst3_n = 1'b0;
      #1;
      req[2] = '0;
      check("l3_rst_ready", 256'(rsp[2].ready), 256'(0));
      check("l3_rst_regs", regq[2], RV_L3);
      @(negedge clk);
      check("l3_rst_bus_wr", 256'(bwr[2]), 256'(0));
      rst3_n = 1'b1;
      sync();
      txn(2, "l3_wr1", 32'h4, 1'b1, 32'h12121212, 4'hF, 3, 32'h0, 1'b0);
      post(2, "l3_wr1", 8'h02);
      check("l3_wr1_reg1", 256'(slice(2, 1)), 256'(32'h12121212));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
